rv_fetch: RTL
=============

Name: rv_fetch

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Keeps the fetch PC and issues word requests on a req/gnt/rvalid instruction-memory bus, with at most one request outstanding.
- Buffers returned words, each with its PC, in a small FIFO and presents them to the decoder through a valid/ready handshake.
- Handles redirects from branches and jumps by flushing the FIFO and discarding any in-flight response.

Parameters:
- BOOT_ADDR, 32'h0000_0000: PC of the first fetch after reset. Bits [1:0] must be 0.
- FIFO_DEPTH, 2: number of instruction-buffer entries. Legal range 2..8.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- imem_req_o  output  1  memory request valid.
- imem_addr_o  output  32  word-aligned fetch address.
- imem_gnt_i  input  1  request accepted this cycle.
- imem_rvalid_i  input  1  read data valid; exactly one per grant, earliest one cycle after the grant.
- imem_rdata_i  input  32  instruction word.
- redirect_i  input  1  taken branch/jump; flush and refetch.
- redirect_pc_i  input  32  target PC; bits [1:0] are ignored and forced to 0.
- instr_valid_o  output  1  instruction available to the decoder.
- instr_ready_i  input  1  decoder accepts the head entry.
- instr_o  output  32  head instruction word; feeds the decoder's instruction input.
- instr_pc_o  output  32  PC of the head instruction.

Behaviour:

Reset:
- rst_ni low clears all state asynchronously.
- After reset: imem_req_o=0, imem_addr_o=BOOT_ADDR, fetch_pc=BOOT_ADDR, FIFO empty, instr_valid_o=0, instr_o=0, instr_pc_o=0, discard flag=0, state IDLE.
- Reset mid-transaction abandons the transaction. imem_rvalid_i received while in IDLE or REQ is ignored.

FSM states:
- IDLE: no request outstanding.
- REQ: imem_req_o=1, waiting for grant.
- WAIT: granted, waiting for imem_rvalid_i.

FSM transitions:
- IDLE -> REQ when FIFO count < FIFO_DEPTH. With an empty FIFO this occurs on the first clock edge after rst_ni rises, so imem_req_o is high in the next cycle.
- REQ -> WAIT on imem_gnt_i. On the same edge fetch_pc <= fetch_pc+4, wrapping mod 2^32 (32'hFFFF_FFFC -> 0).
- WAIT -> REQ on imem_rvalid_i if the post-update FIFO count < FIFO_DEPTH; otherwise WAIT -> IDLE.

Memory bus rules:
- imem_addr_o = fetch_pc.
- While in REQ, imem_req_o and imem_addr_o stay stable until the grant, even if a redirect arrives.
- The response to every issued request is always accepted, so imem_rvalid_i is never stalled.
- A response is issued only when a FIFO slot is free and nothing else is outstanding, so it always has space.

FIFO:
- Push {imem_rdata_i, PC of that request} on imem_rvalid_i in WAIT when the discard flag is 0.
- instr_valid_o = (count != 0). instr_o and instr_pc_o show the head entry.
- Pop on instr_valid_o && instr_ready_i.
- Push and pop in the same cycle leave the count unchanged.
- Read and write pointers wrap modulo FIFO_DEPTH.
- instr_o and instr_pc_o hold their last value when the FIFO is empty and are not cleared by a flush.

Redirect (highest priority, takes effect on the edge where redirect_i=1):
- FIFO emptied; instr_valid_o=0 next cycle. A same-cycle pop and any same-cycle push are ignored.
- fetch_pc <= {redirect_pc_i[31:2],2'b00}, except in REQ without a same-cycle grant: the current request completes at the old address.
- If a request is outstanding (WAIT, or REQ being granted or not yet granted), the discard flag is set. Its response is dropped and clears the flag.
- A redirect that lands in REQ without a same-cycle grant stores the target PC as pending; the target is loaded into fetch_pc on the grant edge in place of +4.
- After the discarded response the FSM goes to REQ with the target address.
- Back-to-back redirects: the last one wins.

Throughput:
- Fetch-to-decoder latency is one cycle after rvalid.
- With one-cycle grant and one-cycle rvalid, throughput is one instruction per 2 cycles.

Test Plan:
- Reset, BOOT_ADDR=32'h100, gnt and rvalid each one cycle after their trigger, ready=1 -> addresses 0x100, 0x104, 0x108 issued; instr_pc_o follows the same sequence with matching rdata.
- instr_ready_i=0 with FIFO_DEPTH=2 -> exactly 2 entries buffered and imem_req_o stays 0 (IDLE). Raise ready -> both pop in order, then fetching resumes at 0x108.
- Redirect to 32'h2002 while in WAIT -> the in-flight response is dropped, FIFO flushed, next request address is 0x2000, first delivered instr_pc_o=0x2000.
- Redirect while imem_req_o=1 and gnt withheld for 3 cycles -> imem_addr_o stays at the old address until granted; that response is discarded, then a request is issued at the target.
- fetch_pc=32'hFFFF_FFFC -> the following request address is 32'h0000_0000.
- Assert rst_ni low during WAIT, deliver rvalid while in reset and in the first cycle after reset -> nothing is pushed; refetch starts at BOOT_ADDR.

Source files
------------

// File: rtl/rv_fetch.sv
// Instruction fetch: one outstanding req/gnt/rvalid read, PC-tagged FIFO feeding the decoder.
// Latency: a returned word is presented to the decoder the cycle after its rvalid.
// Backpressure: decoder stalls via instr_ready_i; fetching pauses (IDLE) while the FIFO is full.
module rv_fetch #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;      // PC of the request currently outstanding
  logic [31:0]   pend_pc;     // redirect target captured while a request awaits grant
  logic          pend_vld;
  logic          discard;     // drop the next response (it belongs to a flushed path)
  logic [31:0]   target;

  logic [31:0]   mem_instr [FIFO_DEPTH];
  logic [31:0]   mem_pc    [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_inc, rd_inc;
  logic [CW-1:0] count, count_nxt;
  logic          push, pop;
  logic          unused_pc_lsbs;

  assign target         = {redirect_pc_i[31:2], 2'b00};
  assign unused_pc_lsbs = ^redirect_pc_i[1:0];

  assign imem_req_o    = (state == REQ);
  assign imem_addr_o   = fetch_pc;
  assign instr_valid_o = (count != '0);

  // A redirect overrides any same-cycle push or pop.
  assign push = (state == WAIT) && imem_rvalid_i && !discard && !redirect_i;
  assign pop  = instr_valid_o && instr_ready_i && !redirect_i;

  assign wr_inc = (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
  assign rd_inc = (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;

  // Occupancy after this edge; the FSM uses it to decide whether to fetch again.
  always_comb begin
    count_nxt = count;
    if (redirect_i) begin
      count_nxt = '0;
    end else if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end
  end

  // Fetch FSM: PC sequencing, redirect capture and response discard.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      fetch_pc <= BOOT_ADDR;
      req_pc   <= BOOT_ADDR;
      pend_pc  <= '0;
      pend_vld <= 1'b0;
      discard  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_i) fetch_pc <= target;
          if (count < DEPTH_C) state <= REQ;
        end
        REQ: begin
          if (imem_gnt_i) begin
            state    <= WAIT;
            req_pc   <= fetch_pc;
            pend_vld <= 1'b0;
            if (redirect_i) begin
              fetch_pc <= target;
              discard  <= 1'b1;
            end else if (pend_vld) begin
              fetch_pc <= pend_pc;
            end else begin
              fetch_pc <= fetch_pc + 32'd4;
            end
          end else if (redirect_i) begin
            // Address must stay stable until granted; apply the target afterwards.
            pend_pc  <= target;
            pend_vld <= 1'b1;
            discard  <= 1'b1;
          end
        end
        WAIT: begin
          if (redirect_i) fetch_pc <= target;
          if (imem_rvalid_i) begin
            discard <= 1'b0;
            state   <= (count_nxt < DEPTH_C) ? REQ : IDLE;
          end else if (redirect_i) begin
            discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers, occupancy and the registered head outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      instr_o    <= '0;
      instr_pc_o <= '0;
    end else begin
      count <= count_nxt;
      if (redirect_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_inc;
        if (pop)  rd_ptr <= rd_inc;
        if (pop) begin
          if (count == ONE_C) begin
            if (push) begin
              instr_o    <= imem_rdata_i;
              instr_pc_o <= req_pc;
            end
          end else begin
            instr_o    <= mem_instr[rd_inc];
            instr_pc_o <= mem_pc[rd_inc];
          end
        end else if (count == '0 && push) begin
          instr_o    <= imem_rdata_i;
          instr_pc_o <= req_pc;
        end
      end
    end
  end

  // FIFO storage.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_instr[wr_ptr] <= imem_rdata_i;
      mem_pc[wr_ptr]    <= req_pc;
    end
  end

endmodule
